// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A digit at or above this value is bumped by 3 before the doubling shift.
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

    // ceil(w * log10(2)), using a fixed-point approximation of log10(2).
    // w * log10(2) is never an integer for w > 0, so the rounding is exact.
    function automatic int min_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD nibble of the shift-and-add-3 correction: d >= 5 ? d + 3 : d.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= BCD_ADJ_THRESH) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready on both
// sides, optional two's-complement input, sticky overflow and leading-zero blanking.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 18,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  signed_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             state_reg;
    logic [BIN_W-1:0]   sh_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               overflow_reg;
    logic               neg_reg;
    logic [DIGITS-1:0]  blank_reg;

    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_next;
    logic [DIGITS-1:0]  blank_next;
    logic [BIN_W-1:0]   mag;
    logic               is_neg;
    logic               carry_out;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .d (acc_reg[4*gi +: 4]),
                .q (acc_adj[4*gi +: 4])
            );
        end
    endgenerate

    // The bit shifted out of the top digit is worth 10^DIGITS; it is 1 exactly
    // when the adjusted top digit is >= 8, i.e. the pre-adjust digit was >= 5.
    assign acc_next  = {acc_adj[ACC_W-2:0], sh_reg[BIN_W-1]};
    assign carry_out = acc_adj[ACC_W-1];

    // Negating the most negative value wraps to 2^(BIN_W-1), which is the
    // correct magnitude when read back as unsigned.
    assign is_neg = signed_mode & bin[BIN_W-1];
    assign mag    = is_neg ? (~bin + BIN_W'(1)) : bin;

    // Blanking chain runs from the top digit down; the units digit is never blanked.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_units
                assign blank_next[gi] = 1'b0;
            end else if (gi == DIGITS - 1) begin : g_top
                assign blank_next[gi] = (acc_next[4*gi +: 4] == 4'd0);
            end else begin : g_mid
                assign blank_next[gi] = (acc_next[4*gi +: 4] == 4'd0) & blank_next[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sh_reg       <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            overflow_reg <= 1'b0;
            neg_reg      <= 1'b0;
            blank_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sh_reg       <= mag;
                        acc_reg      <= '0;
                        cnt_reg      <= '0;
                        overflow_reg <= 1'b0;
                        neg_reg      <= is_neg;
                        blank_reg    <= '0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_reg <= acc_next;
                    sh_reg  <= {sh_reg[BIN_W-2:0], 1'b0};
                    cnt_reg <= cnt_reg + 1'b1;
                    if (carry_out) begin
                        overflow_reg <= 1'b1;
                    end
                    if (cnt_reg == CNT_LAST) begin
                        blank_reg <= blank_next;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign bcd       = acc_reg;
    assign neg       = neg_reg;
    assign overflow  = overflow_reg;
    assign blank     = blank_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised and directed bench for bin2bcd_seq, checked against a decimal reference model.
module tb_bin2bcd_seq;
    import bcd_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, signed_mode, out_ready;
    logic [17:0] bin;
    logic        in_ready, out_valid, neg, overflow;
    logic [23:0] bcd;
    logic [5:0]  blank;

    logic        in_valid2, out_ready2;
    logic [17:0] bin2;
    logic        in_ready2, out_valid2, neg2, overflow2;
    logic [7:0]  bcd2;
    logic [1:0]  blank2;

    int n_checks = 0;
    int n_errors = 0;

    bin2bcd_seq #(.BIN_W(18), .DIGITS(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .bin(bin), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .bcd(bcd), .neg(neg), .overflow(overflow), .blank(blank)
    );

    bin2bcd_seq #(.BIN_W(18), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .bin(bin2), .signed_mode(1'b0), .out_valid(out_valid2),
        .out_ready(out_ready2), .bcd(bcd2), .neg(neg2), .overflow(overflow2), .blank(blank2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal reference: magnitude by integer arithmetic, digits by repeated /10.
    function automatic void ref_model(input logic [17:0] b, input logic sm, input int nd,
                                      output logic [31:0] e_bcd, output logic e_neg,
                                      output logic e_ovf, output logic [31:0] e_blank);
        longint mag, lim, low, p;
        e_neg = sm && b[17];
        mag   = e_neg ? (longint'(1) << 18) - longint'(b) : longint'(b);
        lim   = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        e_ovf   = (mag >= lim);
        low     = mag % lim;
        e_bcd   = '0;
        e_blank = '0;
        p       = 1;
        for (int i = 0; i < nd; i++) begin
            e_bcd[4*i +: 4] = 4'((low / p) % 10);
            if (i > 0 && (low / p) == 0) e_blank[i] = 1'b1;
            p = p * 10;
        end
    endfunction

    task automatic do_conv(input logic [17:0] b, input logic sm, input int hold, input bit poke);
        logic [31:0] e_bcd, e_blank;
        logic        e_neg, e_ovf;
        int          n;
        ref_model(b, sm, 6, e_bcd, e_neg, e_ovf, e_blank);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        bin = b; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            if (poke) begin
                in_valid = 1'($urandom); bin = 18'($urandom); signed_mode = 1'($urandom);
            end
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(n), 32'd18);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        chk("bcd", 32'(bcd), e_bcd);
        chk("neg", 32'(neg), 32'(e_neg));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        chk("blank", 32'(blank), e_blank);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; bin = 18'($urandom);
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_bcd", 32'(bcd), e_bcd);
            chk("hold_flags", {29'd0, neg, overflow, 1'b0} | 32'(blank) << 3,
                {29'd0, e_neg, e_ovf, 1'b0} | e_blank << 3);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        $display("conv bin=0x%05h signed=%0d -> bcd=0x%06h neg=%0d ovf=%0d blank=%06b",
                 b, sm, bcd, neg, overflow, blank);
    endtask

    task automatic conv2(input logic [17:0] b);
        logic [31:0] e_bcd, e_blank;
        logic        e_neg, e_ovf;
        int          n;
        ref_model(b, 1'b0, 2, e_bcd, e_neg, e_ovf, e_blank);
        chk("d2_in_ready", 32'(in_ready2), 32'd1);
        bin2 = b; in_valid2 = 1'b1; out_ready2 = 1'b0;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("d2_latency", 32'(n), 32'd18);
        chk("d2_bcd", 32'(bcd2), e_bcd);
        chk("d2_overflow", 32'(overflow2), 32'(e_ovf));
        chk("d2_blank", 32'(blank2), e_blank);
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        $display("conv2 bin=%0d -> bcd=0x%02h ovf=%0d blank=%02b", b, bcd2, overflow2, blank2);
    endtask

    initial begin
        int spurious;
        rst_n = 1'b0; in_valid = 1'b0; signed_mode = 1'b0; out_ready = 1'b0; bin = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; bin2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_flags", {29'd0, neg, overflow, 1'b0} | 32'(blank) << 3, 32'd0);
        rst_n = 1'b1;
        chk("min_digits_18", 32'(min_digits(18)), 32'd6);

        do_conv(18'd42, 1'b0, 0, 0);
        do_conv(18'd262143, 1'b0, 0, 0);
        do_conv(18'd0, 1'b0, 0, 0);
        do_conv(18'h3FFD6, 1'b1, 0, 0);
        do_conv(18'h20000, 1'b1, 0, 0);
        do_conv(18'd777, 1'b0, 5, 1);
        do_conv(18'd123, 1'b0, 0, 0);

        // Abort a conversion part-way through SHIFT.
        bin = 18'h3FFD6; signed_mode = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_bcd", 32'(bcd), 32'd0);
        chk("abort_flags", {29'd0, neg, overflow, 1'b0} | 32'(blank) << 3, 32'd0);
        spurious = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        chk("abort_no_out_valid", 32'(spurious), 32'd0);
        do_conv(18'd999, 1'b0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            do_conv(18'($urandom), 1'($urandom), int'($urandom_range(0, 2)), bit'($urandom));
        end

        conv2(18'd999);
        conv2(18'd99);
        conv2(18'd100);
        conv2(18'd7);
        for (int i = 0; i < 4; i++) conv2(18'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
